// File: rtl/knn_topk_core.sv
// Streaming K-nearest-neighbour engine: 3-stage squared-distance pipeline feeding a sorted top-K list.
// Optional majority vote over the kept labels is built when KNN_VOTE_EN is defined.
module knn_topk_core #(
   parameter int DATA_W  = 32,
   parameter int K       = 4,
   parameter int LABEL_W = 8
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       en,
   input  logic                       start,
   input  logic [DATA_W/2-1:0]        test_x,
   input  logic [DATA_W/2-1:0]        test_y,
   input  logic                       pt_valid,
   output logic                       pt_ready,
   input  logic [DATA_W/2-1:0]        pt_x,
   input  logic [DATA_W/2-1:0]        pt_y,
   input  logic [LABEL_W-1:0]         pt_label,
   input  logic                       pt_last,
   output logic                       busy,
   output logic                       done,
   output logic [K*DATA_W-1:0]        nn_dist,
   output logic [K*LABEL_W-1:0]       nn_label,
   output logic [$clog2(K+1)-1:0]     nn_count,
`ifdef KNN_VOTE_EN
   output logic [LABEL_W-1:0]         vote_label,
`endif
   output logic [2:0]                 dbg_state
);

   localparam int H  = DATA_W / 2;
   localparam int CW = $clog2(K + 1);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_LOAD  = 3'd1,
      S_DRAIN = 3'd2,
      S_VOTE  = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   state_t state, state_nxt;
   logic   drain_cnt;
`ifdef KNN_VOTE_EN
   logic [CW-1:0] vote_cnt;
`endif

   logic [H-1:0] tx_q, ty_q;

   // Point stream: a point transfers on any edge where pt_valid & pt_ready are both high.
   logic hs, start_acc;
   assign pt_ready  = (state == S_LOAD) & en;
   assign hs        = pt_valid & pt_ready;
   assign start_acc = start & (state == S_IDLE) & en;
   assign busy      = (state == S_LOAD) | (state == S_DRAIN) | (state == S_VOTE);
   assign dbg_state = state;

   // Pipeline registers: p0 captures the point, s1 holds differences, s2 holds distance.
   logic               p0_v, s1_v, s2_v;
   logic [H-1:0]       p0_x, p0_y;
   logic [LABEL_W-1:0] p0_l, s1_l, s2_l;
   logic [H:0]         s1_dx, s1_dy;
   logic [DATA_W-1:0]  s2_d;

   logic [DATA_W-1:0]  dist_q  [K];
   logic [LABEL_W-1:0] label_q [K];
   logic [CW-1:0]      count_q;

   logic [H:0]         dx_c, dy_c;
   logic [DATA_W+1:0]  dxw, dyw, sqx, sqy, sum_c;
   logic [DATA_W-1:0]  dist_c;

   always_comb begin
      dx_c   = {p0_x[H-1], p0_x} - {tx_q[H-1], tx_q};
      dy_c   = {p0_y[H-1], p0_y} - {ty_q[H-1], ty_q};
      dxw    = {{(H+1){s1_dx[H]}}, s1_dx};
      dyw    = {{(H+1){s1_dy[H]}}, s1_dy};
      sqx    = dxw * dxw;
      sqy    = dyw * dyw;
      sum_c  = sqx + sqy;
      dist_c = (|sum_c[DATA_W+1:DATA_W]) ? {DATA_W{1'b1}} : sum_c[DATA_W-1:0];
   end

   // Sorted insert: le[] is a prefix of slots that stay put (ties keep the earlier point ahead).
   logic [K-1:0]       slot_v, le;
   logic [DATA_W-1:0]  ins_d [K];
   logic [LABEL_W-1:0] ins_l [K];
   logic [CW-1:0]      count_nxt;

   always_comb begin
      for (int i = 0; i < K; i++) begin
         slot_v[i] = (CW'(i) < count_q);
         le[i]     = slot_v[i] && (dist_q[i] <= s2_d);
      end
      ins_d[0] = le[0] ? dist_q[0]  : s2_d;
      ins_l[0] = le[0] ? label_q[0] : s2_l;
      for (int i = 1; i < K; i++) begin
         if (le[i]) begin
            ins_d[i] = dist_q[i];
            ins_l[i] = label_q[i];
         end else if (le[i-1]) begin
            ins_d[i] = s2_d;
            ins_l[i] = s2_l;
         end else begin
            ins_d[i] = dist_q[i-1];
            ins_l[i] = label_q[i-1];
         end
      end
      count_nxt = (count_q < CW'(K)) ? count_q + CW'(1) : count_q;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (start) state_nxt = S_LOAD;
         S_LOAD:  if (hs && pt_last) state_nxt = S_DRAIN;
`ifdef KNN_VOTE_EN
         S_DRAIN: if (drain_cnt) state_nxt = S_VOTE;
         S_VOTE:  if (vote_cnt == CW'(K - 1)) state_nxt = S_DONE;
`else
         S_DRAIN: if (drain_cnt) state_nxt = S_DONE;
`endif
         S_DONE:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= S_IDLE;
         drain_cnt <= 1'b0;
`ifdef KNN_VOTE_EN
         vote_cnt  <= '0;
`endif
      end else if (en) begin
         state     <= state_nxt;
         drain_cnt <= (state == S_DRAIN) && !drain_cnt;
`ifdef KNN_VOTE_EN
         vote_cnt  <= (state == S_VOTE) ? vote_cnt + CW'(1) : '0;
`endif
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         tx_q  <= '0;
         ty_q  <= '0;
         p0_v  <= 1'b0;
         p0_x  <= '0;
         p0_y  <= '0;
         p0_l  <= '0;
         s1_v  <= 1'b0;
         s1_dx <= '0;
         s1_dy <= '0;
         s1_l  <= '0;
         s2_v  <= 1'b0;
         s2_d  <= '0;
         s2_l  <= '0;
      end else if (en) begin
         if (start_acc) begin
            tx_q <= test_x;
            ty_q <= test_y;
         end
         p0_v <= hs;
         if (hs) begin
            p0_x <= pt_x;
            p0_y <= pt_y;
            p0_l <= pt_label;
         end
         s1_v  <= p0_v;
         s1_dx <= dx_c;
         s1_dy <= dy_c;
         s1_l  <= p0_l;
         s2_v  <= s1_v;
         s2_d  <= dist_c;
         s2_l  <= s1_l;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < K; i++) begin
            dist_q[i]  <= {DATA_W{1'b1}};
            label_q[i] <= '0;
         end
         count_q <= '0;
      end else if (en) begin
         if (start_acc) begin
            for (int i = 0; i < K; i++) begin
               dist_q[i]  <= {DATA_W{1'b1}};
               label_q[i] <= '0;
            end
            count_q <= '0;
         end else if (s2_v) begin
            for (int i = 0; i < K; i++) begin
               dist_q[i]  <= ins_d[i];
               label_q[i] <= ins_l[i];
            end
            count_q <= count_nxt;
         end
      end
   end

   // done lands on the same edge as the final list update; a frozen engine never pulses it.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) done <= 1'b0;
      else      done <= en && (state == S_DONE);
   end

`ifdef KNN_VOTE_EN
   logic [CW-1:0]      occ [K];
   logic [CW-1:0]      best_c;
   logic [LABEL_W-1:0] vote_c;

   // Strict '>' while scanning upward makes the lowest-index slot win ties.
   always_comb begin
      best_c = '0;
      vote_c = label_q[0];
      for (int i = 0; i < K; i++) begin
         occ[i] = '0;
         for (int j = 0; j < K; j++)
            if (slot_v[j] && (label_q[j] == label_q[i])) occ[i] = occ[i] + CW'(1);
      end
      for (int i = 0; i < K; i++) begin
         if (slot_v[i] && (occ[i] > best_c)) begin
            best_c = occ[i];
            vote_c = label_q[i];
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)                          vote_label <= '0;
      else if (en && (state == S_DONE))  vote_label <= vote_c;
   end
`endif

   for (genvar g = 0; g < K; g++) begin : g_pack
      assign nn_dist[g*DATA_W +: DATA_W]    = dist_q[g];
      assign nn_label[g*LABEL_W +: LABEL_W] = label_q[g];
   end
   assign nn_count = count_q;

endmodule

// File: tb/tb_knn_topk_core.sv
// Directed bench for knn_topk_core: queued expected lists checked at each done pulse.
// Vote checks are compiled in when KNN_VOTE_EN is defined.
module tb_knn_topk_core;

   localparam int DATA_W  = 32;
   localparam int K       = 4;
   localparam int LABEL_W = 8;
   localparam int H       = DATA_W / 2;
   localparam int CW      = $clog2(K + 1);
   localparam int W       = K*DATA_W + K*LABEL_W + CW;
`ifdef KNN_VOTE_EN
   localparam int LAT = 3 + K;
`else
   localparam int LAT = 3;
`endif

   logic                   clk, rst, en, start;
   logic [H-1:0]           test_x, test_y, pt_x, pt_y;
   logic                   pt_valid, pt_ready, pt_last;
   logic [LABEL_W-1:0]     pt_label;
   logic                   busy, done;
   logic [K*DATA_W-1:0]    nn_dist;
   logic [K*LABEL_W-1:0]   nn_label;
   logic [CW-1:0]          nn_count;
   logic [2:0]             dbg_state;
`ifdef KNN_VOTE_EN
   logic [LABEL_W-1:0]     vote_label;
   logic [LABEL_W-1:0]     vote_q[$];
`endif

   logic [W-1:0] exp_q[$];
   int n_tests, n_fail, cyc, last_hs;
   int px[16], py[16], pl[16];
   int tx, ty;

   knn_topk_core #(.DATA_W(DATA_W), .K(K), .LABEL_W(LABEL_W)) dut (
      .clk(clk), .rst(rst), .en(en), .start(start),
      .test_x(test_x), .test_y(test_y),
      .pt_valid(pt_valid), .pt_ready(pt_ready),
      .pt_x(pt_x), .pt_y(pt_y), .pt_label(pt_label), .pt_last(pt_last),
      .busy(busy), .done(done),
      .nn_dist(nn_dist), .nn_label(nn_label), .nn_count(nn_count),
`ifdef KNN_VOTE_EN
      .vote_label(vote_label),
`endif
      .dbg_state(dbg_state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;
   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_reset(input string tag);
      check({tag, "_busy"}, 128'(busy), 128'(0));
      check({tag, "_ready"}, 128'(pt_ready), 128'(0));
      check({tag, "_done"}, 128'(done), 128'(0));
      check({tag, "_count"}, 128'(nn_count), 128'(0));
      check({tag, "_dist"}, 128'(nn_dist), {128{1'b1}});
      check({tag, "_label"}, 128'(nn_label), 128'(0));
   endtask

   task automatic push_lit(input logic [K*DATA_W-1:0] d, input logic [K*LABEL_W-1:0] l, input int c);
      exp_q.push_back({d, l, CW'(c)});
   endtask

   // Reference: slot s takes the smallest remaining distance, earliest point on ties.
   task automatic push_model(input int n);
      longint d[16];
      bit used[16];
      logic [K*DATA_W-1:0] ed;
      logic [K*LABEL_W-1:0] el;
      int best, c, bc;
      ed = '1;
      el = '0;
      for (int i = 0; i < n; i++) begin
         d[i] = longint'(px[i]-tx)*longint'(px[i]-tx) + longint'(py[i]-ty)*longint'(py[i]-ty);
         if (d[i] > 64'hFFFF_FFFF) d[i] = 64'hFFFF_FFFF;
         used[i] = 0;
      end
      for (int s = 0; s < K && s < n; s++) begin
         best = -1;
         for (int i = 0; i < n; i++)
            if (!used[i] && (best < 0 || d[i] < d[best])) best = i;
         used[best] = 1;
         ed[s*DATA_W +: DATA_W]    = d[best][DATA_W-1:0];
         el[s*LABEL_W +: LABEL_W]  = LABEL_W'(pl[best]);
      end
      push_lit(ed, el, (n < K) ? n : K);
`ifdef KNN_VOTE_EN
      bc = 0;
      vote_q.push_back(el[LABEL_W-1:0]);
      for (int s = 0; s < K && s < n; s++) begin
         c = 0;
         for (int j = 0; j < K && j < n; j++)
            if (el[j*LABEL_W +: LABEL_W] == el[s*LABEL_W +: LABEL_W]) c++;
         if (c > bc) begin
            bc = c;
            vote_q[$] = el[s*LABEL_W +: LABEL_W];
         end
      end
`else
      best = 0; c = 0; bc = 0;
`endif
   endtask

   task automatic send_point(input int i, input bit rnd, input bit last);
      int idle;
      bit got;
      idle = rnd ? int'($urandom_range(0, 2)) : 0;
      pt_valid = 1'b0;
      repeat (idle) begin @(posedge clk); #1; end
      pt_x = H'(px[i]);
      pt_y = H'(py[i]);
      pt_label = LABEL_W'(pl[i]);
      pt_last = last;
      pt_valid = 1'b1;
      got = 0;
      for (int w = 0; w < 50 && !got; w++) begin
         @(negedge clk);
         if (pt_ready) begin
            got = 1;
            last_hs = cyc + 1;
         end
         @(posedge clk); #1;
      end
      pt_valid = 1'b0;
      pt_last = 1'b0;
      check("hs_timeout", 128'(got), 128'(1));
   endtask

   task automatic freeze5(input bit in_load);
      en = 1'b0;
      repeat (5) begin
         @(negedge clk);
         check("freeze_ready", 128'(pt_ready), 128'(0));
         check("freeze_done", 128'(done), 128'(0));
         check("freeze_busy", 128'(busy), 128'(1));
         if (!in_load) check("freeze_state", 128'(dbg_state), 128'(2));
         @(posedge clk); #1;
      end
      en = 1'b1;
   endtask

   task automatic run_query(input string tag, input int n, input bit rnd, input int drop_idx,
                            input bit drain_stall);
      logic [W-1:0] e;
      bit got;
      int done_edge;
      test_x = H'(tx);
      test_y = H'(ty);
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      for (int i = 0; i < n; i++) begin
         if (i == drop_idx) freeze5(1'b1);
         send_point(i, rnd, i == n - 1);
      end
      if (drain_stall) freeze5(1'b0);
      got = 0;
      done_edge = 0;
      for (int w = 0; w < 100 && !got; w++) begin
         @(negedge clk);
         if (done) begin
            got = 1;
            done_edge = cyc;
         end
      end
      check({tag, "_done_seen"}, 128'(got), 128'(1));
      check({tag, "_latency"}, 128'(done_edge - last_hs), 128'(LAT + (drain_stall ? 5 : 0)));
      e = exp_q.pop_front();
      for (int s = 0; s < K; s++) begin
         check($sformatf("%s_dist%0d", tag, s), 128'(nn_dist[s*DATA_W +: DATA_W]),
               128'(e[CW + K*LABEL_W + s*DATA_W +: DATA_W]));
         check($sformatf("%s_label%0d", tag, s), 128'(nn_label[s*LABEL_W +: LABEL_W]),
               128'(e[CW + s*LABEL_W +: LABEL_W]));
      end
      check({tag, "_count"}, 128'(nn_count), 128'(e[CW-1:0]));
`ifdef KNN_VOTE_EN
      @(negedge clk);
      check({tag, "_vote"}, 128'(vote_label), 128'(vote_q.pop_front()));
`else
      @(negedge clk);
`endif
      check({tag, "_pulse"}, 128'(done), 128'(0));
      check({tag, "_idle"}, 128'(busy), 128'(0));
      check({tag, "_stable"}, 128'(nn_count), 128'(e[CW-1:0]));
      @(posedge clk); #1;
   endtask

   task automatic load_t1();
      tx = 0; ty = 0;
      px[0] = 3; py[0] = 4; pl[0] = 1;
      px[1] = 1; py[1] = 1; pl[1] = 2;
      px[2] = 0; py[2] = 2; pl[2] = 3;
      px[3] = 5; py[3] = 5; pl[3] = 4;
      px[4] = 1; py[4] = 0; pl[4] = 5;
   endtask

   task automatic push_t1();
      push_lit({32'd25, 32'd4, 32'd2, 32'd1}, {8'd1, 8'd3, 8'd2, 8'd5}, 4);
`ifdef KNN_VOTE_EN
      vote_q.push_back(8'd5);
`endif
   endtask

   initial begin
      n_tests = 0;
      n_fail = 0;
      last_hs = 0;
      rst = 1'b0; en = 1'b1; start = 1'b0;
      test_x = '0; test_y = '0;
      pt_valid = 1'b0; pt_x = '0; pt_y = '0; pt_label = '0; pt_last = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_reset("reset");
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;

      // T1: basic query, back-to-back points
      load_t1();
      push_t1();
      run_query("t1", 5, 1'b0, -1, 1'b0);

      // T2: equal distances keep arrival order
      tx = 0; ty = 0;
      px[0] = 1; py[0] = 0; pl[0] = 7;
      px[1] = 0; py[1] = 1; pl[1] = 8;
      push_lit({32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 32'd1}, {8'd0, 8'd0, 8'd8, 8'd7}, 2);
`ifdef KNN_VOTE_EN
      vote_q.push_back(8'd7);
`endif
      run_query("t2", 2, 1'b0, -1, 1'b0);

      // T3: extreme corners saturate instead of wrapping
      tx = -32768; ty = -32768;
      px[0] = 32767; py[0] = 32767; pl[0] = 9;
      push_lit({32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF},
               {8'd0, 8'd0, 8'd0, 8'd9}, 1);
`ifdef KNN_VOTE_EN
      vote_q.push_back(8'd9);
`endif
      run_query("t3", 1, 1'b0, -1, 1'b0);

      // T4: random valid gaps plus a 5-cycle freeze with a point in flight
      load_t1();
      push_t1();
      run_query("t4", 5, 1'b1, 2, 1'b0);

      // T4b: freeze right after the last handshake delays done by 5
      load_t1();
      push_t1();
      run_query("t4b", 5, 1'b0, -1, 1'b1);

      // T5: reset in the middle of LOAD, then a fresh query
      load_t1();
      test_x = '0; test_y = '0;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      send_point(0, 1'b0, 1'b0);
      send_point(1, 1'b0, 1'b0);
      rst = 1'b0;
      @(negedge clk);
      check_reset("t5_rst");
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      push_t1();
      run_query("t5", 5, 1'b0, -1, 1'b0);

      // T6: nearest labels 3,5,3,5 -> majority tie resolves to slot 0's label
      tx = 0; ty = 0;
      px[0] = 1; py[0] = 0; pl[0] = 3;
      px[1] = 1; py[1] = 1; pl[1] = 5;
      px[2] = 0; py[2] = 2; pl[2] = 3;
      px[3] = 2; py[3] = 1; pl[3] = 5;
      px[4] = 3; py[4] = 3; pl[4] = 9;
      push_lit({32'd5, 32'd4, 32'd2, 32'd1}, {8'd5, 8'd3, 8'd5, 8'd3}, 4);
`ifdef KNN_VOTE_EN
      vote_q.push_back(8'd3);
`endif
      run_query("t6", 5, 1'b0, -1, 1'b0);

      // Random queries checked against the selection model
      for (int q = 0; q < 3; q++) begin
         tx = int'($urandom_range(0, 200)) - 100;
         ty = int'($urandom_range(0, 200)) - 100;
         for (int i = 0; i < 7; i++) begin
            px[i] = int'($urandom_range(0, 200)) - 100;
            py[i] = int'($urandom_range(0, 200)) - 100;
            pl[i] = int'($urandom_range(0, 3));
         end
         push_model(7);
         run_query($sformatf("rnd%0d", q), 7, 1'b1, -1, 1'b0);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
